evm_ballot_ctrl: RTL and testbench

- Clocked, parametrised successor of the team's 4-party push-button EVM counter.
- Supports N parties and configurable counter width.
- Synchronises and debounces the vote button and arms one vote per ballot issued by the presiding officer.
- Rejects non-one-hot selections, saturates counters, and exposes per-party and total tallies through a select-based readout port for the display layer.

---
 rtl/evm_ballot_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_evm_ballot_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_ballot_ctrl.sv
// Ballot controller: button sync/debounce, one-vote-per-ballot FSM, saturating party tallies and registered readout.
// Build option: define EVM_LEADER_EN to add the leader_idx / leader_tie outputs.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no ballot armed; presses ignored, waiting for officer strobe
// S_ARMED  | one vote armed; next valid press is counted
// S_LOCKED | vote just consumed; presses and strobes ignored for a while
module evm_ballot_ctrl #(
    parameter int N_PARTY     = 4,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int LOCK_CYCLES = 8,
    localparam int SEL_W      = $clog2(N_PARTY),
    localparam int TOT_W      = CNT_W + SEL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               voting_en,
    input  logic               ballot_issue,
    input  logic               push_button,
    input  logic [N_PARTY-1:0] voter_switch,
    input  logic               clear_counts,
    input  logic [SEL_W-1:0]   sel_party,
    output logic [CNT_W-1:0]   party_count,
    output logic [TOT_W-1:0]   total_count,
    output logic               armed,
    output logic               vote_accepted,
    output logic               invalid_vote,
    output logic               sat_flag
`ifdef EVM_LEADER_EN
    ,
    output logic [SEL_W-1:0]   leader_idx,
    output logic               leader_tie
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb_level;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               r_press;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LOCK_W-1:0]  r_lock_cnt;
    logic               w_vote;
    logic               w_bad;
    logic               w_one_hot;
    logic [SEL_W-1:0]   w_sw_idx;
    logic               w_clear;

    logic [CNT_W-1:0]   r_cnt [N_PARTY];
    logic [TOT_W-1:0]   r_total;
    logic               r_sat;
    logic [CNT_W-1:0]   w_sel_cnt;
    logic [CNT_W-1:0]   r_party_count;
    logic [TOT_W-1:0]   r_total_count;
    logic               r_vote_acc;
    logic               r_invalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= push_button;
            r_sync2 <= r_sync1;
        end
    end

    // Down-counter reloads whenever the synced sample agrees with the held level;
    // the level flips on the DEB_CYCLES-th consecutive disagreeing sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_level <= 1'b0;
            r_deb_cnt   <= DEB_LOAD;
            r_press     <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_deb_level) begin
                r_deb_cnt <= DEB_LOAD;
            end else if (r_deb_cnt == '0) begin
                r_deb_level <= r_sync2;
                r_deb_cnt   <= DEB_LOAD;
                r_press     <= r_sync2;
            end else begin
                r_deb_cnt <= r_deb_cnt - DEB_W'(1);
            end
        end
    end

    assign w_one_hot = (voter_switch != '0) &&
                       ((voter_switch & (voter_switch - N_PARTY'(1))) == '0);

    always_comb begin
        w_sw_idx = '0;
        for (int i = 0; i < N_PARTY; i++) begin
            if (voter_switch[i]) w_sw_idx = SEL_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Cancellation by voting_en=0 takes priority over a press in the same clock.
    always_comb begin
        w_state_nxt = r_state;
        w_vote      = 1'b0;
        w_bad       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ballot_issue && voting_en) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (!voting_en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_press) begin
                    if (w_one_hot) begin
                        w_vote      = 1'b1;
                        w_state_nxt = S_LOCKED;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (r_lock_cnt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_cnt <= '0;
        end else if (w_vote) begin
            r_lock_cnt <= LOCK_LOAD;
        end else if (r_state == S_LOCKED && r_lock_cnt != '0) begin
            r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vote_acc <= 1'b0;
            r_invalid  <= 1'b0;
        end else begin
            r_vote_acc <= w_vote;
            r_invalid  <= w_bad;
        end
    end

    assign w_clear = clear_counts && !voting_en;

    // A vote only happens with voting_en=1, so it can never collide with a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PARTY; i++) r_cnt[i] <= '0;
            r_total <= '0;
            r_sat   <= 1'b0;
        end else if (w_clear) begin
            for (int i = 0; i < N_PARTY; i++) r_cnt[i] <= '0;
            r_total <= '0;
            r_sat   <= 1'b0;
        end else if (w_vote) begin
            if (r_cnt[w_sw_idx] == CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt[w_sw_idx] <= r_cnt[w_sw_idx] + CNT_W'(1);
                r_total         <= r_total + TOT_W'(1);
            end
        end
    end

    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < N_PARTY; i++) begin
            if (sel_party == SEL_W'(i)) w_sel_cnt = r_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_party_count <= '0;
            r_total_count <= '0;
        end else begin
            r_party_count <= w_sel_cnt;
            r_total_count <= r_total;
        end
    end

    assign party_count   = r_party_count;
    assign total_count   = r_total_count;
    assign armed         = (r_state == S_ARMED);
    assign vote_accepted = r_vote_acc;
    assign invalid_vote  = r_invalid;
    assign sat_flag      = r_sat;

`ifdef EVM_LEADER_EN
    logic [CNT_W-1:0] w_max;
    logic [SEL_W-1:0] w_lead;
    logic             w_seen;
    logic             w_tie;
    logic [SEL_W-1:0] r_leader_idx;
    logic             r_leader_tie;

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        w_max  = '0;
        w_lead = '0;
        w_seen = 1'b0;
        w_tie  = 1'b0;
        for (int i = 0; i < N_PARTY; i++) begin
            if (r_cnt[i] > w_max) begin
                w_max  = r_cnt[i];
                w_lead = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_PARTY; i++) begin
            if (r_cnt[i] == w_max) begin
                if (w_seen) w_tie = 1'b1;
                w_seen = 1'b1;
            end
        end
        if (w_max == '0) w_tie = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leader_idx <= '0;
            r_leader_tie <= 1'b0;
        end else begin
            r_leader_idx <= w_lead;
            r_leader_tie <= w_tie;
        end
    end

    assign leader_idx = r_leader_idx;
    assign leader_tie = r_leader_tie;
`endif

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Self-checking bench for evm_ballot_ctrl: vector table, directed corner sequences, randomized ballots vs a tally model.
`timescale 1ns/1ps
module tb_evm_ballot_ctrl;
    localparam int NP   = 4;
    localparam int CW   = 4;
    localparam int DEB  = 4;
    localparam int LOCK = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          voting_en = 1'b0;
    logic          ballot_issue = 1'b0;
    logic          push_button = 1'b0;
    logic [NP-1:0] voter_switch = '0;
    logic          clear_counts = 1'b0;
    logic [1:0]    sel_party = '0;
    logic [CW-1:0] party_count;
    logic [CW+1:0] total_count;
    logic          armed;
    logic          vote_accepted;
    logic          invalid_vote;
    logic          sat_flag;
`ifdef EVM_LEADER_EN
    logic [1:0]    leader_idx;
    logic          leader_tie;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_va    = 0;
    int n_inv   = 0;

    int m_cnt [NP];
    bit m_sat;
    bit m_armed;

    typedef struct {
        logic [NP-1:0] sw;
        int            exp_va;
        int            exp_inv;
        bit            exp_armed;
    } vec_t;
    vec_t vecs [8];

    evm_ballot_ctrl #(
        .N_PARTY(NP), .CNT_W(CW), .DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .voting_en(voting_en), .ballot_issue(ballot_issue),
        .push_button(push_button), .voter_switch(voter_switch), .clear_counts(clear_counts),
        .sel_party(sel_party), .party_count(party_count), .total_count(total_count),
        .armed(armed), .vote_accepted(vote_accepted), .invalid_vote(invalid_vote),
        .sat_flag(sat_flag)
`ifdef EVM_LEADER_EN
        , .leader_idx(leader_idx), .leader_tie(leader_tie)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vote_accepted === 1'b1) n_va++;
        if (invalid_vote === 1'b1) n_inv++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        m_sat = 1'b0;
    endtask

    // Tally rules: one-hot press on an armed ballot counts (saturating), anything else flags invalid.
    task automatic model_press(input logic [NP-1:0] sw, output int eva, output int einv);
        int idx;
        eva  = 0;
        einv = 0;
        idx  = 0;
        if (m_armed) begin
            if ($countones(sw) == 1) begin
                for (int i = 0; i < NP; i++) if (sw[i]) idx = i;
                if (m_cnt[idx] == CMAX) m_sat = 1'b1;
                else m_cnt[idx]++;
                m_armed = 1'b0;
                eva = 1;
            end else begin
                einv = 1;
            end
        end
    endtask

    task automatic press_clean(input int hold);
        push_button = 1'b1;
        tick(hold);
        push_button = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic ballot_press(input logic [NP-1:0] sw, output int dva, output int dinv);
        int va0;
        int inv0;
        va0  = n_va;
        inv0 = n_inv;
        voter_switch = sw;
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        if (voting_en) m_armed = 1'b1;
        press_clean(DEB + 4);
        dva  = n_va - va0;
        dinv = n_inv - inv0;
    endtask

    task automatic cast(input logic [NP-1:0] sw, input string tag);
        int dva, dinv, eva, einv;
        ballot_press(sw, dva, dinv);
        model_press(sw, eva, einv);
        check($sformatf("%s accept sw=%b", tag, sw), dva, eva);
        check($sformatf("%s invalid sw=%b", tag, sw), dinv, einv);
    endtask

    task automatic check_all(input string tag);
        int sum;
        sum = 0;
        for (int p = 0; p < NP; p++) begin
            sel_party = 2'(p);
            tick(2);
            check($sformatf("%s party%0d", tag, p), party_count, m_cnt[p]);
            sum += m_cnt[p];
        end
        check($sformatf("%s total", tag), total_count, sum);
        check($sformatf("%s sat_flag", tag), sat_flag, m_sat);
        check($sformatf("%s armed", tag), armed, m_armed);
    endtask

    initial begin
        int dva, dinv, va0, inv0, r;
        logic [NP-1:0] sw;

        vecs[0] = '{4'b0110, 0, 1, 1'b1};
        vecs[1] = '{4'b0001, 1, 0, 1'b0};
        vecs[2] = '{4'b0000, 0, 1, 1'b1};
        vecs[3] = '{4'b1111, 0, 1, 1'b1};
        vecs[4] = '{4'b1000, 1, 0, 1'b0};
        vecs[5] = '{4'b0010, 1, 0, 1'b0};
        vecs[6] = '{4'b1010, 0, 1, 1'b1};
        vecs[7] = '{4'b0100, 1, 0, 1'b0};

        model_clear();
        m_armed = 1'b0;

        // reset values
        tick(3);
        check("rst party_count", party_count, 0);
        check("rst total_count", total_count, 0);
        check("rst armed", armed, 0);
        check("rst vote_accepted", vote_accepted, 0);
        check("rst invalid_vote", invalid_vote, 0);
        check("rst sat_flag", sat_flag, 0);
        reset_n = 1'b1;
        tick(2);
        check_all("post_rst");

        // single vote with exact latency
        voting_en = 1'b1;
        voter_switch = 4'b0100;
        sel_party = 2'd2;
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        check("single armed", armed, 1);
        push_button = 1'b1;
        tick(6);
        check("single no early accept", vote_accepted, 0);
        tick(1);
        check("single accept at 2+DEB+1", vote_accepted, 1);
        tick(1);
        check("single pulse width", vote_accepted, 0);
        check("single armed drops", armed, 0);
        check("single party2", party_count, 1);
        check("single total", total_count, 1);
        push_button = 1'b0;
        tick(DEB + 6);
        m_cnt[2] = 1;

        // ballot_issue coincident with press event in IDLE: arm only
        va0 = n_va;
        voter_switch = 4'b0001;
        push_button = 1'b1;
        tick(2 + DEB);
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        check("simul armed", armed, 1);
        check("simul not counted", vote_accepted, 0);
        push_button = 1'b0;
        tick(DEB + 6);
        check("simul no vote", n_va - va0, 0);
        m_armed = 1'b1;
        check_all("simul");

        // table of selections
        for (int i = 0; i < 8; i++) begin
            int eva, einv;
            ballot_press(vecs[i].sw, dva, dinv);
            model_press(vecs[i].sw, eva, einv);
            check($sformatf("vec%0d accept", i), dva, vecs[i].exp_va);
            check($sformatf("vec%0d invalid", i), dinv, vecs[i].exp_inv);
            check($sformatf("vec%0d armed", i), armed, vecs[i].exp_armed);
        end
        check_all("table");

        // bouncy press, toggles during lockout, then press without a ballot
        va0 = n_va;
        voter_switch = 4'b0010;
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        m_armed = 1'b1;
        repeat (3) begin
            push_button = 1'b1;
            tick(3);
            push_button = 1'b0;
            tick(3);
        end
        push_button = 1'b1;
        tick(DEB + 4);
        push_button = 1'b0;
        tick(2);
        push_button = 1'b1;
        tick(2);
        push_button = 1'b0;
        tick(DEB + 6);
        model_press(4'b0010, dva, dinv);
        check("bounce one vote", n_va - va0, 1);
        press_clean(DEB + 4);
        check("no-ballot press ignored", n_va - va0, 1);
        check_all("bounce");

        // saturation on party 3
        voting_en = 1'b0;
        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        voting_en = 1'b1;
        tick(1);
        model_clear();
        m_armed = 1'b0;
        va0 = n_va;
        repeat (16) cast(4'b1000, "sat");
        check("sat pulses", n_va - va0, 16);
        sel_party = 2'd3;
        tick(2);
        check("sat party3", party_count, 15);
        check("sat total", total_count, 15);
        check("sat flag", sat_flag, 1);
        check_all("sat");

        // cancel then clear
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        check("cancel armed before", armed, 1);
        voting_en = 1'b0;
        tick(1);
        check("cancel armed after", armed, 0);
        voting_en = 1'b1;
        m_armed = 1'b0;
        va0 = n_va;
        voter_switch = 4'b0001;
        press_clean(DEB + 4);
        check("cancel press ignored", n_va - va0, 0);
        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        check_all("clear ignored");
        voting_en = 1'b0;
        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        voting_en = 1'b1;
        model_clear();
        check_all("clear");

`ifdef EVM_LEADER_EN
        cast(4'b0010, "lead");
        cast(4'b0010, "lead");
        cast(4'b1000, "lead");
        cast(4'b1000, "lead");
        tick(2);
        check("leader idx tie", leader_idx, 1);
        check("leader tie", leader_tie, 1);
        cast(4'b1000, "lead");
        tick(2);
        check("leader idx p3", leader_idx, 3);
        check("leader no tie", leader_tie, 0);
        check_all("lead");
`endif

        // randomized ballots against the tally model
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                sw = NP'(1) << $urandom_range(0, NP - 1);
                cast(sw, "rnd_vote");
            end else if (r == 7) begin
                do sw = NP'($urandom_range(0, 15)); while ($countones(sw) == 1);
                cast(sw, "rnd_bad");
            end else if (r == 8) begin
                voting_en = 1'b0;
                tick(2);
                voting_en = 1'b1;
                m_armed = 1'b0;
                tick(1);
            end else begin
                voting_en = 1'b0;
                clear_counts = 1'b1;
                tick(1);
                clear_counts = 1'b0;
                voting_en = 1'b1;
                m_armed = 1'b0;
                model_clear();
                tick(1);
            end
            check_all($sformatf("rnd%0d", t));
        end

        // reset in the middle of an armed ballot
        cast(4'b0001, "pre_rst");
        ballot_issue = 1'b1;
        tick(1);
        ballot_issue = 1'b0;
        m_armed = 1'b1;
        check("midrst armed before", armed, 1);
        reset_n = 1'b0;
        tick(1);
        check("midrst armed", armed, 0);
        check("midrst total", total_count, 0);
        check("midrst sat", sat_flag, 0);
        reset_n = 1'b1;
        model_clear();
        m_armed = 1'b0;
        tick(1);
        check_all("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
